// File: rtl/dbiu_axi4_bridge.sv
// dbiu_axi4_bridge: turns one CPU data-bus access into a single-beat AXI4 write or read.
// Latency: with a zero-wait slave, ack comes 3 cycles after req is first sampled; one access in flight.
// Backpressure: AXI VALIDs hold a stable payload until READY; the CPU holds req until ack.
module dbiu_axi4_bridge #(
  parameter int DBUS_AW   = 32,
  parameter int DBUS_DW   = 32,
  parameter int DBUS_ISEL = 4,
  parameter int AXI_IDW   = 4,
  parameter int AXI_ID    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU side
  input  logic                 req_m2dbiu,
  input  logic [DBUS_AW-1:0]   adr_m2dbiu,
  input  logic [DBUS_DW-1:0]   dat_m2dbiu,
  input  logic                 we_m2dbiu,
  input  logic [DBUS_ISEL-1:0] sel_m2dbiu,
  output logic [DBUS_DW-1:0]   dat_dbiu2m,
  output logic                 ack_dbiu2m,
  output logic                 err_dbiu2m,
  // AXI write address
  output logic [AXI_IDW-1:0]   m_awid,
  output logic [DBUS_AW-1:0]   m_awaddr,
  output logic [7:0]           m_awlen,
  output logic [2:0]           m_awsize,
  output logic [1:0]           m_awburst,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  // AXI write data
  output logic [DBUS_DW-1:0]   m_wdata,
  output logic [DBUS_ISEL-1:0] m_wstrb,
  output logic                 m_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  // AXI write response
  input  logic [AXI_IDW-1:0]   m_bid,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  // AXI read address
  output logic [AXI_IDW-1:0]   m_arid,
  output logic [DBUS_AW-1:0]   m_araddr,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  // AXI read data
  input  logic [AXI_IDW-1:0]   m_rid,
  input  logic [DBUS_DW-1:0]   m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready
);

  localparam logic [2:0] AXSIZE     = 3'($clog2(DBUS_DW / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_ACK
  } state_t;

  state_t                state_q;
  logic [DBUS_AW-1:0]    adr_q;
  logic [DBUS_DW-1:0]    dat_q;
  logic [DBUS_ISEL-1:0]  sel_q;
  logic [DBUS_DW-1:0]    rdat_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  ack_q;
  logic                  err_q;

  logic aw_hs;
  logic w_hs;

  // IDs, single-beat read status and the read-side byte lanes carry no information here
  logic unused_inputs;
  assign unused_inputs = ^{m_bid, m_rid, m_rlast};

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  // Constant burst shape: one full-width INCR beat with a fixed ID
  assign m_awid    = AXI_IDW'(AXI_ID);
  assign m_awlen   = 8'd0;
  assign m_awsize  = AXSIZE;
  assign m_awburst = BURST_INCR;
  assign m_arid    = AXI_IDW'(AXI_ID);
  assign m_arlen   = 8'd0;
  assign m_arsize  = AXSIZE;
  assign m_arburst = BURST_INCR;
  assign m_wlast   = 1'b1;

  // Payload always comes from the captured copy, so CPU-side changes mid-access are ignored
  assign m_awaddr  = adr_q;
  assign m_araddr  = adr_q;
  assign m_wdata   = dat_q;
  assign m_wstrb   = sel_q;

  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  assign dat_dbiu2m = rdat_q;
  assign ack_dbiu2m = ack_q;
  assign err_dbiu2m = err_q;

  // Access sequencer: all handshake and CPU-facing outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses unless re-armed below
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_m2dbiu) begin
            adr_q <= adr_m2dbiu;
            dat_q <= dat_m2dbiu;
            sel_q <= sel_m2dbiu;
            if (we_m2dbiu) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WREQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WREQ: begin
          // AW and W complete independently, in either order or together
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (m_bvalid) begin
            bready_q <= 1'b0;
            err_q    <= (m_bresp != RESP_OKAY);
            ack_q    <= 1'b1;
            state_q  <= S_ACK;
          end
        end
        S_RADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (m_rvalid) begin
            rready_q <= 1'b0;
            rdat_q   <= m_rdata;
            err_q    <= (m_rresp != RESP_OKAY);
            ack_q    <= 1'b1;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          // ack is visible during this state; req is next looked at in IDLE
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbiu_axi4_bridge.sv
// tb_dbiu_axi4_bridge: scoreboard bench with a configurable-delay AXI slave for dbiu_axi4_bridge.
// Latency: expects ack 3 cycles after req is sampled plus any slave wait cycles.
// Backpressure: slave READY/VALID delays are programmed per scenario.
module tb_dbiu_axi4_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_m2dbiu;
  logic [31:0] adr_m2dbiu;
  logic [31:0] dat_m2dbiu;
  logic        we_m2dbiu;
  logic [3:0]  sel_m2dbiu;
  logic [31:0] dat_dbiu2m;
  logic        ack_dbiu2m;
  logic        err_dbiu2m;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [3:0]  m_bid = 4'd0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [3:0]  m_rid = 4'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  dbiu_axi4_bridge dut (
    .clk(clk), .rst(rst),
    .req_m2dbiu(req_m2dbiu), .adr_m2dbiu(adr_m2dbiu), .dat_m2dbiu(dat_m2dbiu),
    .we_m2dbiu(we_m2dbiu), .sel_m2dbiu(sel_m2dbiu),
    .dat_dbiu2m(dat_dbiu2m), .ack_dbiu2m(ack_dbiu2m), .err_dbiu2m(err_dbiu2m),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration (written only by the main initial block)
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;

  // Handshake monitor state (written only by the posedge monitor)
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb, last_awid, last_arid;
  logic [7:0]  last_awlen, last_arlen;
  logic [2:0]  last_awsize, last_arsize;
  logic [1:0]  last_awburst, last_arburst;
  logic        last_wlast;
  logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0, prev_ack = 1'b0;
  logic [31:0] pa_aw, pd_w, pa_ar;
  int          stab_viol = 0, err_viol = 0, ack_viol = 0;

  // Slave responder state (written only by the negedge responder)
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int b_issued = 0, r_issued = 0;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    bit          err;
  } sb_t;
  sb_t sb[$];

  // Records handshakes and payloads, and flags VALID instability and stray err/ack pulses
  always @(posedge clk) begin
    if (!rst) begin
      if (m_awvalid && m_awready) begin
        aw_hs_cnt <= aw_hs_cnt + 1; last_awaddr <= m_awaddr; last_awid <= m_awid;
        last_awlen <= m_awlen; last_awsize <= m_awsize; last_awburst <= m_awburst;
      end
      if (m_wvalid && m_wready) begin
        w_hs_cnt <= w_hs_cnt + 1; last_wdata <= m_wdata; last_wstrb <= m_wstrb; last_wlast <= m_wlast;
      end
      if (m_bvalid && m_bready) b_hs_cnt <= b_hs_cnt + 1;
      if (m_arvalid && m_arready) begin
        ar_hs_cnt <= ar_hs_cnt + 1; last_araddr <= m_araddr; last_arid <= m_arid;
        last_arlen <= m_arlen; last_arsize <= m_arsize; last_arburst <= m_arburst;
      end
      if (m_rvalid && m_rready) r_hs_cnt <= r_hs_cnt + 1;
      stab_viol <= stab_viol
                 + int'(pv_aw && !(m_awvalid && m_awaddr == pa_aw))
                 + int'(pv_w  && !(m_wvalid  && m_wdata  == pd_w))
                 + int'(pv_ar && !(m_arvalid && m_araddr == pa_ar));
      if (err_dbiu2m && !ack_dbiu2m) err_viol <= err_viol + 1;
      if (ack_dbiu2m && prev_ack) ack_viol <= ack_viol + 1;
      pv_aw <= m_awvalid && !m_awready; pa_aw <= m_awaddr;
      pv_w  <= m_wvalid && !m_wready;   pd_w  <= m_wdata;
      pv_ar <= m_arvalid && !m_arready; pa_ar <= m_araddr;
      prev_ack <= ack_dbiu2m;
    end else begin
      pv_aw <= 1'b0; pv_w <= 1'b0; pv_ar <= 1'b0; prev_ack <= 1'b0;
    end
  end

  // AXI slave: READY after a programmed wait, B/R responses after a programmed delay
  always @(negedge clk) begin
    if (rst) begin
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      b_issued = (aw_hs_cnt > w_hs_cnt) ? aw_hs_cnt : w_hs_cnt;
      r_issued = ar_hs_cnt;
    end else begin
      if (m_awready) begin m_awready = 1'b0; aw_wait = 0; end
      else if (m_awvalid) begin if (aw_wait >= aw_dly) m_awready = 1'b1; else aw_wait++; end
      if (m_wready) begin m_wready = 1'b0; w_wait = 0; end
      else if (m_wvalid) begin if (w_wait >= w_dly) m_wready = 1'b1; else w_wait++; end
      if (m_arready) begin m_arready = 1'b0; ar_wait = 0; end
      else if (m_arvalid) begin if (ar_wait >= ar_dly) m_arready = 1'b1; else ar_wait++; end
      if (m_bvalid) begin
        if (b_hs_cnt >= b_issued) m_bvalid = 1'b0;
      end else if (aw_hs_cnt > b_issued && w_hs_cnt > b_issued) begin
        if (b_wait >= b_dly) begin
          m_bvalid = 1'b1; m_bresp = b_resp_cfg; b_issued++; b_wait = 0;
        end else b_wait++;
      end
      if (m_rvalid) begin
        if (r_hs_cnt >= r_issued) m_rvalid = 1'b0;
      end else if (ar_hs_cnt > r_issued) begin
        if (r_wait >= r_dly) begin
          m_rvalid = 1'b1; m_rdata = r_data_cfg; m_rresp = r_resp_cfg; m_rlast = 1'b1;
          r_issued++; r_wait = 0;
        end else r_wait++;
      end
    end
  end

  // Drive a CPU request (called at a negedge) and record what it must produce
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] rd, input bit er);
    sb_t e;
    req_m2dbiu = 1'b1; we_m2dbiu = w; adr_m2dbiu = a; dat_m2dbiu = d; sel_m2dbiu = s;
    e.we = w; e.adr = a; e.dat = d; e.sel = s; e.rdat = rd; e.err = er;
    sb.push_back(e);
  endtask

  // Wait for ack (bounded), then pop the scoreboard and compare the completed access
  task automatic wait_ack(input string nm, input int exp_lat, input bit scramble);
    int lat;
    bit got;
    sb_t e;
    lat = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (scramble && lat == 1) begin
        adr_m2dbiu = ~adr_m2dbiu; dat_m2dbiu = ~dat_m2dbiu; sel_m2dbiu = ~sel_m2dbiu;
      end
      if (ack_dbiu2m) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s ack_timeout: no ack within 200 cycles", nm);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (exp_lat >= 0) begin
        n_checks++;
        if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
      end
      n_checks++;
      if (err_dbiu2m !== e.err) begin n_fail++; $display("FAIL %s err: got %0b want %0b", nm, err_dbiu2m, e.err); end
      if (e.we) begin
        n_checks++;
        if ({last_awaddr, last_wdata, last_wstrb} !== {e.adr, e.dat, e.sel}) begin
          n_fail++;
          $display("FAIL %s aw/w payload: got %h/%h/%h want %h/%h/%h", nm,
                   last_awaddr, last_wdata, last_wstrb, e.adr, e.dat, e.sel);
        end
      end else begin
        n_checks++;
        if (dat_dbiu2m !== e.rdat) begin n_fail++; $display("FAIL %s rdata: got %h want %h", nm, dat_dbiu2m, e.rdat); end
        n_checks++;
        if (last_araddr !== e.adr) begin n_fail++; $display("FAIL %s araddr: got %h want %h", nm, last_araddr, e.adr); end
      end
    end
  endtask

  // Drop req after ack and confirm the ack/err pulse lasted one cycle
  task automatic go_idle(input string nm);
    req_m2dbiu = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({ack_dbiu2m, err_dbiu2m} !== 2'b00) begin
      n_fail++; $display("FAIL %s ack_pulse: ack/err got %b want 00 one cycle later", nm, {ack_dbiu2m, err_dbiu2m});
    end
  endtask

  task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset valid_ready: got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    n_checks++;
    if ({ack_dbiu2m, err_dbiu2m} !== 2'b00) begin
      n_fail++; $display("FAIL reset ack_err: got %b want 00", {ack_dbiu2m, err_dbiu2m});
    end
    n_checks++;
    if (dat_dbiu2m !== 32'h0) begin n_fail++; $display("FAIL reset dat: got %h want 0", dat_dbiu2m); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    int aw0, w0;
    set_slave(0, 0, 0, 0, 0); b_resp_cfg = 2'b00;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    wait_ack("wr_basic", 3, 1'b0);
    go_idle("wr_basic");
    n_checks++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL wr_basic hs_count: aw %0d w %0d want 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    n_checks++;
    if ({last_awid, last_awlen, last_awsize, last_awburst, last_wlast} !== {4'd0, 8'd0, 3'd2, 2'b01, 1'b1}) begin
      n_fail++; $display("FAIL wr_basic aw_const: id %h len %h size %h burst %b wlast %b want 0 0 2 01 1",
                         last_awid, last_awlen, last_awsize, last_awburst, last_wlast);
    end
  endtask

  task automatic test_read_delay();
    int ar0;
    set_slave(0, 0, 0, 0, 5); r_resp_cfg = 2'b00; r_data_cfg = 32'h12345678;
    ar0 = ar_hs_cnt;
    issue(1'b0, 32'h200, 32'h0, 4'h0, 32'h12345678, 1'b0);
    wait_ack("rd_delay", 8, 1'b0);
    go_idle("rd_delay");
    n_checks++;
    if (ar_hs_cnt - ar0 !== 1) begin n_fail++; $display("FAIL rd_delay hs_count: ar %0d want 1", ar_hs_cnt - ar0); end
    n_checks++;
    if ({last_arid, last_arlen, last_arsize, last_arburst} !== {4'd0, 8'd0, 3'd2, 2'b01}) begin
      n_fail++; $display("FAIL rd_delay ar_const: id %h len %h size %h burst %b want 0 0 2 01",
                         last_arid, last_arlen, last_arsize, last_arburst);
    end
  endtask

  task automatic test_write_order();
    int aw0, w0;
    // W accepted 4 cycles before AW; CPU fields scrambled after capture
    set_slave(4, 0, 0, 0, 0); b_resp_cfg = 2'b00;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    issue(1'b1, 32'h300, 32'hA5A50001, 4'h3, 32'h0, 1'b0);
    wait_ack("wr_w_first", 7, 1'b1);
    go_idle("wr_w_first");
    n_checks++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL wr_w_first hs_count: aw %0d w %0d want 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    // AW accepted 4 cycles before W
    set_slave(0, 4, 0, 0, 0);
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    issue(1'b1, 32'h304, 32'h5A5A0002, 4'hC, 32'h0, 1'b0);
    wait_ack("wr_aw_first", 7, 1'b0);
    go_idle("wr_aw_first");
    n_checks++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL wr_aw_first hs_count: aw %0d w %0d want 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
  endtask

  task automatic test_error_resp();
    set_slave(0, 0, 0, 0, 0);
    r_resp_cfg = 2'b10; r_data_cfg = 32'hCAFEF00D;
    issue(1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);
    wait_ack("rd_slverr", 3, 1'b0);
    go_idle("rd_slverr");
    r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
    issue(1'b1, 32'h404, 32'h11112222, 4'hF, 32'h0, 1'b0);
    wait_ack("wr_okay_after_err", 3, 1'b0);
    go_idle("wr_okay_after_err");
    n_checks++;
    if (dat_dbiu2m !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL dat_hold: got %h want cafef00d after write", dat_dbiu2m);
    end
    b_resp_cfg = 2'b10;
    issue(1'b1, 32'h408, 32'h33334444, 4'h1, 32'h0, 1'b1);
    wait_ack("wr_slverr", 3, 1'b0);
    go_idle("wr_slverr");
    b_resp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    int aw0, w0, ar0;
    set_slave(0, 0, 0, 0, 0); b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h0BADCAFE;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; ar0 = ar_hs_cnt;
    // sel=0 write is still issued on the bus
    issue(1'b1, 32'h500, 32'h77778888, 4'h0, 32'h0, 1'b0);
    wait_ack("b2b_write", 3, 1'b0);
    // New request presented in the ack cycle; sampled in the following IDLE cycle
    issue(1'b0, 32'h504, 32'h0, 4'hF, 32'h0BADCAFE, 1'b0);
    wait_ack("b2b_read", 4, 1'b0);
    go_idle("b2b_read");
    n_checks++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0, ar_hs_cnt - ar0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL b2b hs_count: aw %0d w %0d ar %0d want 1 1 1",
                         aw_hs_cnt - aw0, w_hs_cnt - w0, ar_hs_cnt - ar0);
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b scoreboard: %0d left want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    set_slave(0, 0, 0, 1000, 0); r_resp_cfg = 2'b00;
    issue(1'b0, 32'h600, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid arvalid_pre: got %b want 1", m_arvalid); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_arvalid, ack_dbiu2m, m_rready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid immediate: arvalid/ack/rready got %b want 000", {m_arvalid, ack_dbiu2m, m_rready});
    end
    sb.delete();
    req_m2dbiu = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    set_slave(0, 0, 0, 0, 0); r_data_cfg = 32'h600DF00D;
    @(negedge clk);
    issue(1'b0, 32'h604, 32'h0, 4'h0, 32'h600DF00D, 1'b0);
    wait_ack("rd_after_rst", 3, 1'b0);
    go_idle("rd_after_rst");
  endtask

  task automatic test_protocol();
    n_checks++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL valid_stable: %0d violations want 0", stab_viol); end
    n_checks++;
    if (err_viol !== 0) begin n_fail++; $display("FAIL err_without_ack: %0d events want 0", err_viol); end
    n_checks++;
    if (ack_viol !== 0) begin n_fail++; $display("FAIL ack_multi_cycle: %0d events want 0", ack_viol); end
  endtask

  initial begin
    rst = 1'b1; req_m2dbiu = 1'b0; adr_m2dbiu = '0; dat_m2dbiu = '0; we_m2dbiu = 1'b0; sel_m2dbiu = '0;
    set_slave(0, 0, 0, 0, 0);
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h0;
    test_reset();
    test_write_basic();
    test_read_delay();
    test_write_order();
    test_error_resp();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
